// File: rtl/twos_comp_rx.sv
// Serial two's-complement negation receiver: LSB-first bit stream in, negated word out.
// Define TWOS_COMP_RX_DROP_CNT_EN to add the saturating drop_cnt output.
module twos_comp_rx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             incode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             frame_err,
  output logic             drop
`ifdef TWOS_COMP_RX_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [0:0] COPY   = 1'b0;
  localparam logic [0:0] INVERT = 1'b1;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    idx;
  logic [0:0]       state;
  logic [0:0]       eff_state;
  logic [0:0]       next_state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] word;
  logic             accept;
  logic             err;
  logic             rec_bit;
  logic             complete;
  logic             word_ovf;
  logic             load;

  // A bit flagged in_first always restarts from COPY at index 0 with a clean word.
  always_comb begin
    accept    = 1'b0;
    err       = 1'b0;
    idx       = cnt;
    eff_state = state;
    base      = sr;
    if (in_valid) begin
      if (in_first) begin
        accept    = 1'b1;
        err       = (cnt != '0);
        idx       = '0;
        eff_state = COPY;
        base      = '0;
      end else if (cnt == '0) begin
        err = 1'b1;
      end else begin
        accept = 1'b1;
      end
    end
    rec_bit    = (eff_state == COPY) ? incode : ~incode;
    next_state = (eff_state == COPY && incode) ? INVERT : eff_state;
    word       = (base & ~(WIDTH'(1) << idx)) | (WIDTH'(rec_bit) << idx);
    complete   = accept && (idx == CW'(WIDTH - 1));
    word_ovf   = (word == {1'b1, {(WIDTH-1){1'b0}}});
    load       = complete && (!out_valid || out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      state     <= COPY;
      sr        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      frame_err <= 1'b0;
      drop      <= 1'b0;
    end else begin
      frame_err <= err;
      drop      <= complete && !load;
      if (accept) begin
        if (complete) begin
          cnt   <= '0;
          state <= COPY;
          sr    <= '0;
        end else begin
          cnt   <= idx + CW'(1);
          state <= next_state;
          sr    <= word;
        end
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= word;
        out_ovf   <= word_ovf;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef TWOS_COMP_RX_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (complete && !load && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_twos_comp_rx.sv
// Scoreboard bench for twos_comp_rx (WIDTH=8): expected words come from arithmetic negation.
module tb_twos_comp_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_first = 1'b0;
  logic       incode = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ovf;
  logic       frame_err;
  logic       drop;
`ifdef TWOS_COMP_RX_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_miss = 0;
  int unsigned err_seen = 0;
  int unsigned drop_seen = 0;
  logic [8:0]  sb_q[$];

  twos_comp_rx #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .incode    (incode),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .frame_err (frame_err),
    .drop      (drop)
`ifdef TWOS_COMP_RX_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] x);
    logic [7:0] neg;
    neg = 8'(0 - int'(x));
    return {(neg == 8'h80), neg};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) err_seen++;
      if (drop) drop_seen++;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_word", {23'd0, out_ovf, out_data}, 32'h1ff);
        end else begin
          check("word", {23'd0, out_ovf, out_data}, {23'd0, sb_q.pop_front()});
        end
      end
    end
  end

  task automatic drive(input logic v, input logic f, input logic c);
    in_valid = v;
    in_first = f;
    incode   = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] x, input bit push, input int unsigned max_gap);
    logic [7:0] xv;
    xv = x;
    if (push) sb_q.push_back(model(xv));
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0), xv[i]);
      if (i < 7 && max_gap > 0) repeat ($urandom_range(max_gap, 0)) drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", sb_q.size(), 0);
  endtask

  initial begin
    int unsigned e0;
    logic [7:0] f7f;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", {frame_err, drop, out_ovf}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 0xFB -> 0x05 with latency 1
    send_frame(8'hFB, 1, 0);
    check("latency_valid", out_valid, 1);
    check("fb_data", out_data, 8'h05);
    drain();

    // boundaries: zero and the unrepresentable negation
    send_frame(8'h00, 1, 0);
    send_frame(8'h80, 1, 0);
    drain();

    // backpressure: second word dropped, first held
    out_ready = 1'b0;
    send_frame(8'h01, 1, 0);
    send_frame(8'h02, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("bp_hold_data", out_data, 8'hFF);
    check("bp_hold_valid", out_valid, 1);
    check("bp_drop_count", drop_seen, 1);
`ifdef TWOS_COMP_RX_DROP_CNT_EN
    check("drop_cnt", drop_cnt, 1);
`endif
    out_ready = 1'b1;
    drain();
    check("bp_valid_clear", out_valid, 0);

    // restart mid-frame with gaps inside the new frame
    e0 = err_seen;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    sb_q.push_back(model(8'h7F));
    f7f = 8'h7F;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0), f7f[i]);
      if (i == 2 || i == 5) drive(1'b0, 1'b0, 1'b0);
    end
    drain();
    check("restart_err", err_seen - e0, 1);
    check("restart_data", out_data, 8'h81);

    // reset mid-frame, then a non-first bit while idle
    for (int i = 0; i < 4; i++) drive(1'b1, (i == 0), 1'b1);
    rst = 1'b1;
    #2;
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    e0 = err_seen;
    drive(1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("idle_err", err_seen - e0, 1);
    check("idle_no_word", out_valid, 0);
    send_frame(8'h10, 1, 0);
    drain();
    check("post_rst_data", out_data, 8'hF0);

    // random frames with random gaps
    for (int n = 0; n < 12; n++) send_frame(8'($urandom), 1, 2);
    send_frame(8'h7F, 1, 0);
    send_frame(8'hFF, 1, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
